// File: rtl/pipeline_trace_unit.sv
// Pipeline event recorder: snapshots per-stage acks, retirements and flushes into a FIFO and
// serializes them as Kanata-style records on an AXI-Stream master. Optional flush capture: OFFNARISCV_TRACE_FLUSH_EN.
module pipeline_trace_unit #(
  parameter int NUM_STAGES = 5,
  parameter int ID_WIDTH   = 16,
  parameter int DEPTH      = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [NUM_STAGES-1:0]          stage_ack,
  input  logic [NUM_STAGES*ID_WIDTH-1:0] stage_id,
  input  logic                           retire_valid,
  input  logic [ID_WIDTH-1:0]            retire_id,
  input  logic                           flush_valid,
  input  logic [ID_WIDTH-1:0]            flush_first,
  input  logic [ID_WIDTH-1:0]            flush_last,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [63:0]                    m_tdata,
  output logic                           m_tlast,
  output logic [15:0]                    drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  // m_tvalid/m_tready: a record transfers on a rising edge where both are high; while
  // m_tvalid is high and m_tready low, m_tdata and m_tlast hold their values.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CYC = 3'd1, S_OVF = 3'd2, S_STG = 3'd3, S_RET = 3'd4
`ifdef OFFNARISCV_TRACE_FLUSH_EN
    , S_FLU = 3'd5
`endif
  } state_t;

  state_t state, state_n, succ, tail_ret, tail_stg, tail_ovf;
  logic [4:0] stg_idx, stg_n, succ_idx, first_i, nxt_i;
  logic first_v, nxt_v, last, fire, push, pop, drop, evt, flush_in, full, empty;

  logic [31:0] cyc_cnt, ret_cnt;
  logic [15:0] pend;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;

  logic [31:0]                    mem_cyc  [DEPTH];
  logic [NUM_STAGES-1:0]          mem_ack  [DEPTH];
  logic [NUM_STAGES*ID_WIDTH-1:0] mem_ids  [DEPTH];
  logic                           mem_rv   [DEPTH];
  logic [ID_WIDTH-1:0]            mem_rid  [DEPTH];
  logic [15:0]                    mem_drop [DEPTH];
  logic                           h_fv;
  logic [ID_WIDTH-1:0]            h_ff, h_fl;

`ifdef OFFNARISCV_TRACE_FLUSH_EN
  logic                mem_fv [DEPTH];
  logic [ID_WIDTH-1:0] mem_ff [DEPTH];
  logic [ID_WIDTH-1:0] mem_fl [DEPTH];
  assign flush_in = flush_valid;
  assign h_fv = mem_fv[rd_ptr];
  assign h_ff = mem_ff[rd_ptr];
  assign h_fl = mem_fl[rd_ptr];
  always_ff @(posedge clk) begin
    if (push) begin
      mem_fv[wr_ptr] <= flush_valid;
      mem_ff[wr_ptr] <= flush_first;
      mem_fl[wr_ptr] <= flush_last;
    end
  end
`else
  logic unused_flush;
  assign unused_flush = ^{flush_valid, flush_first, flush_last};
  assign flush_in = 1'b0;
  assign h_fv = 1'b0;
  assign h_ff = '0;
  assign h_fl = '0;
`endif

  assign evt   = en & (|stage_ack | retire_valid | flush_in);
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign fire  = m_tvalid & m_tready;
  assign pop   = fire & last;
  // A full FIFO that pops this cycle still accepts the new snapshot.
  assign push  = evt & (~full | pop);
  assign drop  = evt & full & ~pop;

  always_comb begin
    first_v = 1'b0;
    first_i = '0;
    nxt_v   = 1'b0;
    nxt_i   = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (mem_ack[rd_ptr][i]) begin
        first_v = 1'b1;
        first_i = 5'(i);
      end
      if (mem_ack[rd_ptr][i] && i > int'(stg_idx)) begin
        nxt_v = 1'b1;
        nxt_i = 5'(i);
      end
    end
  end

  // Successor record of the current one; S_IDLE marks the end of the snapshot.
  always_comb begin
`ifdef OFFNARISCV_TRACE_FLUSH_EN
    tail_ret = h_fv ? S_FLU : S_IDLE;
`else
    tail_ret = S_IDLE;
`endif
    tail_stg = mem_rv[rd_ptr] ? S_RET : tail_ret;
    tail_ovf = first_v ? S_STG : tail_stg;
    succ     = S_IDLE;
    succ_idx = first_i;
    case (state)
      S_CYC: succ = (mem_drop[rd_ptr] != 16'd0) ? S_OVF : tail_ovf;
      S_OVF: succ = tail_ovf;
      S_STG: begin
        succ     = nxt_v ? S_STG : tail_stg;
        succ_idx = nxt_i;
      end
      S_RET:   succ = tail_ret;
      default: succ = S_IDLE;
    endcase
    last = (succ == S_IDLE);
  end

  always_comb begin
    state_n = state;
    stg_n   = stg_idx;
    if (state == S_IDLE) begin
      if (!empty || push) state_n = S_CYC;
    end else if (fire) begin
      if (last) begin
        state_n = (count > (AW+1)'(1) || push) ? S_CYC : S_IDLE;
      end else begin
        state_n = succ;
        stg_n   = succ_idx;
      end
    end
  end

  always_comb begin
    m_tvalid = (state != S_IDLE);
    m_tlast  = m_tvalid & last;
    m_tdata  = '0;
    case (state)
      S_CYC: m_tdata = {3'd0, 5'd0, 24'd0, mem_cyc[rd_ptr]};
      S_OVF: m_tdata = {3'd4, 5'd0, 24'd0, 16'd0, mem_drop[rd_ptr]};
      S_STG: m_tdata = {3'd1, stg_idx,
                        24'(mem_ids[rd_ptr][int'(stg_idx)*ID_WIDTH +: ID_WIDTH]), 32'd0};
      S_RET: m_tdata = {3'd2, 5'd0, 24'(mem_rid[rd_ptr]), ret_cnt};
`ifdef OFFNARISCV_TRACE_FLUSH_EN
      S_FLU: m_tdata = {3'd3, 5'd0, 24'(h_ff), 32'(h_fl)};
`endif
      default: m_tdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_cyc[wr_ptr]  <= cyc_cnt;
      mem_ack[wr_ptr]  <= stage_ack;
      mem_ids[wr_ptr]  <= stage_id;
      mem_rv[wr_ptr]   <= retire_valid;
      mem_rid[wr_ptr]  <= retire_id;
      mem_drop[wr_ptr] <= pend;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      stg_idx  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cyc_cnt  <= '0;
      ret_cnt  <= '0;
      pend     <= '0;
      drop_cnt <= '0;
    end else begin
      state   <= state_n;
      stg_idx <= stg_n;
      cyc_cnt <= cyc_cnt + 32'd1;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (fire && state == S_RET) ret_cnt <= ret_cnt + 32'd1;
      if (push) pend <= '0;
      else if (drop && pend != 16'hFFFF) pend <= pend + 16'd1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipeline_trace_unit.sv
// Directed bench for pipeline_trace_unit: expected records are queued when an event is
// driven and compared as the stream hands them over. Honors OFFNARISCV_TRACE_FLUSH_EN.
module tb_pipeline_trace_unit;
  localparam int NS = 5;
  localparam int IW = 16;
  localparam int DP = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b1;
  logic [NS-1:0]     stage_ack = '0;
  logic [NS*IW-1:0]  stage_id = '0;
  logic              retire_valid = 1'b0;
  logic [IW-1:0]     retire_id = '0;
  logic              flush_valid = 1'b0;
  logic [IW-1:0]     flush_first = '0;
  logic [IW-1:0]     flush_last = '0;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [63:0]       m_tdata;
  logic              m_tlast;
  logic [15:0]       drop_cnt;

  pipeline_trace_unit #(.NUM_STAGES(NS), .ID_WIDTH(IW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .en(en), .stage_ack(stage_ack), .stage_id(stage_id),
    .retire_valid(retire_valid), .retire_id(retire_id), .flush_valid(flush_valid),
    .flush_first(flush_first), .flush_last(flush_last), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast), .drop_cnt(drop_cnt)
  );

  // clock / reset-tracking block
  always #5 clk = ~clk;

  logic [31:0] tb_cyc;
  always @(posedge clk) begin
    if (rst) tb_cyc <= '0;
    else     tb_cyc <= tb_cyc + 32'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [64:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int tlast_seen = 0;
  logic [31:0] tb_ret = '0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [64:0] rec(input logic [2:0] k, input logic [4:0] s,
                                      input logic [23:0] id, input logic [31:0] p);
    return {1'b0, k, s, id, p};
  endfunction

  task automatic push_snap(input logic [NS-1:0] ack, input logic [NS*IW-1:0] ids,
                           input logic rv, input logic [IW-1:0] rid, input logic fv,
                           input logic [IW-1:0] ff, input logic [IW-1:0] fl,
                           input logic [15:0] drop);
    logic [64:0] q[$];
    q.push_back(rec(3'd0, 5'd0, 24'd0, tb_cyc));
    if (drop != 16'd0) q.push_back(rec(3'd4, 5'd0, 24'd0, {16'd0, drop}));
    for (int i = 0; i < NS; i++)
      if (ack[i]) q.push_back(rec(3'd1, 5'(i), 24'(ids[i*IW +: IW]), 32'd0));
    if (rv) begin
      q.push_back(rec(3'd2, 5'd0, 24'(rid), tb_ret));
      tb_ret++;
    end
`ifdef OFFNARISCV_TRACE_FLUSH_EN
    if (fv) q.push_back(rec(3'd3, 5'd0, 24'(ff), 32'(fl)));
`else
    if (fv && ff == fl) q = q;
`endif
    q[q.size()-1][64] = 1'b1;
    foreach (q[i]) exp_q.push_back(q[i]);
  endtask

  // driver: one event cycle, starting #1 after a rising edge
  task automatic drive(input logic [NS-1:0] ack, input logic [NS*IW-1:0] ids,
                       input logic rv, input logic [IW-1:0] rid, input logic fv,
                       input logic [IW-1:0] ff, input logic [IW-1:0] fl,
                       input bit expect_snap, input logic [15:0] drop);
    stage_ack = ack; stage_id = ids; retire_valid = rv; retire_id = rid;
    flush_valid = fv; flush_first = ff; flush_last = fl;
    if (expect_snap) push_snap(ack, ids, rv, rid, fv, ff, fl, drop);
    @(posedge clk); #1;
    stage_ack = '0; retire_valid = 1'b0; flush_valid = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !m_tvalid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check(tag, 65'(done), 65'd1);
  endtask

  // output monitor, sampled on the falling edge
  logic        stalled_prev = 1'b0;
  logic [64:0] held_prev;
  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) check("stall_hold", {m_tlast, m_tdata}, held_prev);
      if (m_tvalid && m_tready) begin
        if (m_tlast) tlast_seen++;
        if (exp_q.size() == 0) check("unexpected_record", {m_tlast, m_tdata}, 65'd0);
        else check("record", {m_tlast, m_tdata}, exp_q.pop_front());
      end
      stalled_prev = m_tvalid && !m_tready;
      held_prev = {m_tlast, m_tdata};
    end
  end

  logic [NS*IW-1:0] ids;
  int cnt;
  int tl0;

  initial begin
    // reset values
    rst = 1'b1;
    step(3);
    check("rst_tvalid", 65'(m_tvalid), 65'd0);
    check("rst_tdata", 65'(m_tdata), 65'd0);
    check("rst_tlast", 65'(m_tlast), 65'd0);
    check("rst_drop_cnt", 65'(drop_cnt), 65'd0);
    rst = 1'b0;

    // two stage acks at cycle 10, three consecutive records
    cnt = 0;
    while (tb_cyc != 32'd10 && cnt < 50) begin
      step(1);
      cnt++;
    end
    ids = '0; ids[0*IW +: IW] = 16'd3; ids[2*IW +: IW] = 16'd7;
    drive(5'b00101, ids, 1'b0, '0, 1'b0, '0, '0, 1'b1, 16'd0);
    check("first_valid_latency", 65'(m_tvalid), 65'd1);
    cnt = 0;
    while (m_tvalid && cnt < 20) begin
      cnt++;
      step(1);
    end
    check("burst_len", 65'(cnt), 65'd3);
    wait_drain("drain_stage");

    // two retirements five cycles apart
    drive('0, '0, 1'b1, 16'd4, 1'b0, '0, '0, 1'b1, 16'd0);
    step(4);
    drive('0, '0, 1'b1, 16'd4, 1'b0, '0, '0, 1'b1, 16'd0);
    wait_drain("drain_retire");

    // capture disabled: no snapshot
    en = 1'b0;
    drive(5'b00001, ids, 1'b1, 16'd5, 1'b0, '0, '0, 1'b0, 16'd0);
    en = 1'b1;
    step(3);
    check("en_low_no_record", 65'(m_tvalid), 65'd0);

    // overflow: fill with the stream stalled, three snapshots dropped
    m_tready = 1'b0;
    for (int i = 0; i < DP + 3; i++) begin
      ids = '0; ids[0 +: IW] = 16'(i + 1);
      drive(5'b00001, ids, 1'b0, '0, 1'b0, '0, '0, (i < DP), 16'd0);
    end
    step(2);
    check("drop_cnt_3", 65'(drop_cnt), 65'd3);
    m_tready = 1'b1;
    wait_drain("drain_full");
    ids = '0; ids[1*IW +: IW] = 16'h55;
    drive(5'b00010, ids, 1'b0, '0, 1'b0, '0, '0, 1'b1, 16'd3);
    wait_drain("drain_overflow");

    // flush event
`ifdef OFFNARISCV_TRACE_FLUSH_EN
    drive('0, '0, 1'b0, '0, 1'b1, 16'd9, 16'd12, 1'b1, 16'd0);
    wait_drain("drain_flush");
`else
    drive('0, '0, 1'b0, '0, 1'b1, 16'd9, 16'd12, 1'b0, 16'd0);
    step(3);
    check("flush_ignored", 65'(m_tvalid), 65'd0);
`endif

    // four-record snapshot under random backpressure
    m_tready = 1'b0;
    tl0 = tlast_seen;
    ids = '0; ids[1*IW +: IW] = 16'h11; ids[4*IW +: IW] = 16'h44;
    drive(5'b10010, ids, 1'b1, 16'h21, 1'b0, '0, '0, 1'b1, 16'd0);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && !m_tvalid) break;
      m_tready = 1'($urandom_range(0, 1));
      step(1);
    end
    m_tready = 1'b1;
    wait_drain("drain_random");
    check("one_tlast", 65'(tlast_seen - tl0), 65'd1);

    // reset while emitting stage records
    m_tready = 1'b0;
    ids = '0; ids[1*IW +: IW] = 16'hA1; ids[2*IW +: IW] = 16'hA2; ids[3*IW +: IW] = 16'hA3;
    drive(5'b01110, ids, 1'b0, '0, 1'b0, '0, '0, 1'b1, 16'd0);
    m_tready = 1'b1;
    step(1);
    m_tready = 1'b0;
    step(1);
    check("stalled_in_stage", {m_tlast, m_tdata}, rec(3'd1, 5'd1, 24'hA1, 32'd0));
    rst = 1'b1;
    exp_q.delete();
    tb_ret = '0;
    step(1);
    check("mid_rst_tvalid", 65'(m_tvalid), 65'd0);
    check("mid_rst_drop_cnt", 65'(drop_cnt), 65'd0);
    rst = 1'b0;
    m_tready = 1'b1;
    step(10);
    check("no_stale_records", 65'(m_tvalid), 65'd0);
    drive('0, '0, 1'b1, 16'h9, 1'b0, '0, '0, 1'b1, 16'd0);
    wait_drain("drain_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
